// File: rtl/seq_det_pkg.sv
// Shared types and defaults for the programmable serial pattern detector.
// Holds the length-field width helper, the overlap-mode encoding and the
// reset-time configuration constants used by seq_detector_prog.
package seq_det_pkg;

    // Width needed to hold a pattern length of 0..max_len.
    function automatic int len_width(input int max_len);
        return $clog2(max_len + 1);
    endfunction

    localparam int          DEF_MAX_LEN   = 8;
    localparam int          LEN_W         = len_width(DEF_MAX_LEN);
    localparam logic [7:0]  DEF_PATTERN_C = 8'b0000_1010;
    localparam int          DEF_LEN_C     = 4;
    localparam bit          DEF_OVERLAP_C = 1'b1;
    localparam int          DEF_CNT_W     = 16;

    typedef enum logic {
        MODE_NONOVL = 1'b0,
        MODE_OVL    = 1'b1
    } ovl_mode_e;

endpackage

// File: rtl/seq_det_sat_cnt.sv
// Saturating up-counter with synchronous clear.
// Latency: count updates on the edge that sees inc; clear and inc together give 1.
// Backpressure: none; inc is ignored once the count is all ones.
//
// Ports: clk, rst_n (async active-low), clr (sync clear), inc (count enable), cnt (value).
module seq_det_sat_cnt #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] cnt
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            // A clear coinciding with an event still records that event.
            cnt <= inc ? W'(1) : '0;
        end else if (inc && (cnt != '1)) begin
            cnt <= cnt + W'(1);
        end
    end

endmodule

// File: rtl/seq_detector_prog.sv
// Runtime-programmable serial bit-pattern detector (1..MAX_LEN bits, overlap selectable).
// Latency: last pattern bit sampled on edge N gives a one-cycle z pulse in the cycle after N.
// Backpressure: none; x is taken whenever x_valid is high, except on a cfg_load edge where it is dropped.
//
// Ports: clk/rst_n (async active-low); x/x_valid serial input; cfg_load/cfg_pattern/cfg_len/
// cfg_overlap configuration, cfg_err flags a rejected load; z match pulse.
// Optional macro SEQ_DET_MATCH_CNT_EN adds match_cnt (saturating count) and cnt_clr.
module seq_detector_prog
    import seq_det_pkg::*;
#(
    parameter int                 MAX_LEN     = DEF_MAX_LEN,
    parameter logic [MAX_LEN-1:0] DEF_PATTERN = MAX_LEN'(DEF_PATTERN_C),
    parameter int                 DEF_LEN     = DEF_LEN_C,
    parameter bit                 DEF_OVERLAP = DEF_OVERLAP_C
`ifdef SEQ_DET_MATCH_CNT_EN
    ,
    parameter int                 CNT_W       = DEF_CNT_W
`endif
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           x,
    input  logic                           x_valid,
    input  logic                           cfg_load,
    input  logic [MAX_LEN-1:0]             cfg_pattern,
    input  logic [len_width(MAX_LEN)-1:0]  cfg_len,
    input  logic                           cfg_overlap,
    output logic                           cfg_err,
    output logic                           z
`ifdef SEQ_DET_MATCH_CNT_EN
    ,
    output logic [CNT_W-1:0]               match_cnt,
    input  logic                           cnt_clr
`endif
);

    localparam int            LW        = len_width(MAX_LEN);
    localparam logic [LW-1:0] MAX_LEN_L = LW'(MAX_LEN);

    // Active configuration.
    logic [MAX_LEN-1:0] pattern_q;
    logic [LW-1:0]      len_q;
    ovl_mode_e          overlap_q;

    // Only MAX_LEN-1 past bits are kept: together with the incoming bit they
    // form the full MAX_LEN-bit window, and the oldest bit would be shifted
    // out before it could ever be compared.
    logic [MAX_LEN-2:0] hist_q;
    logic [LW-1:0]      fill_q;

    logic [MAX_LEN-1:0] hist_nxt;
    logic [MAX_LEN-1:0] len_mask;
    logic [LW-1:0]      fill_inc;
    logic               accept;
    logic               hit;
    logic               cfg_ok;

    always_comb begin
        hist_nxt = {hist_q, x};
        fill_inc = (fill_q == MAX_LEN_L) ? fill_q : fill_q + LW'(1);
        // Only the low len bits of pattern and window take part in the compare.
        len_mask = '0;
        for (int i = 0; i < MAX_LEN; i++) begin
            len_mask[i] = (LW'(i) < len_q);
        end
        accept = x_valid & ~cfg_load;
        hit    = accept && (fill_inc >= len_q)
                 && (((hist_nxt ^ pattern_q) & len_mask) == '0);
        cfg_ok = (cfg_len != '0) && (cfg_len <= MAX_LEN_L);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pattern_q <= DEF_PATTERN;
            len_q     <= LW'(DEF_LEN);
            overlap_q <= ovl_mode_e'(DEF_OVERLAP);
            hist_q    <= '0;
            fill_q    <= '0;
            z         <= 1'b0;
            cfg_err   <= 1'b0;
        end else begin
            z       <= 1'b0;
            cfg_err <= 1'b0;
            if (cfg_load) begin
                // Any x_valid on a load edge is dropped, accepted load or not.
                if (cfg_ok) begin
                    pattern_q <= cfg_pattern;
                    len_q     <= cfg_len;
                    overlap_q <= ovl_mode_e'(cfg_overlap);
                    hist_q    <= '0;
                    fill_q    <= '0;
                end else begin
                    cfg_err <= 1'b1;
                end
            end else if (x_valid) begin
                hist_q <= hist_nxt[MAX_LEN-2:0];
                // Non-overlapping mode demands len fresh bits after each match.
                fill_q <= (hit && (overlap_q == MODE_NONOVL)) ? '0 : fill_inc;
                z      <= hit;
            end
        end
    end

`ifdef SEQ_DET_MATCH_CNT_EN
    seq_det_sat_cnt #(
        .W (CNT_W)
    ) u_match_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (cnt_clr),
        .inc   (hit),
        .cnt   (match_cnt)
    );
`endif

endmodule

// File: tb/tb_seq_detector_prog.sv
// Directed self-checking bench for seq_detector_prog (MAX_LEN=8; CNT_W=4 when the counter is built).
module tb_seq_detector_prog;

    localparam int MAX_LEN = 8;
    localparam int LW      = 4;

    logic               clk = 1'b0;
    logic               rst_n;
    logic               x;
    logic               x_valid;
    logic               cfg_load;
    logic [MAX_LEN-1:0] cfg_pattern;
    logic [LW-1:0]      cfg_len;
    logic               cfg_overlap;
    logic               cfg_err;
    logic               z;
`ifdef SEQ_DET_MATCH_CNT_EN
    logic [3:0]         match_cnt;
    logic               cnt_clr;
`endif

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    seq_detector_prog #(
        .MAX_LEN     (8),
        .DEF_PATTERN (8'b0000_1010),
        .DEF_LEN     (4),
        .DEF_OVERLAP (1'b1)
`ifdef SEQ_DET_MATCH_CNT_EN
        ,
        .CNT_W       (4)
`endif
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .x           (x),
        .x_valid     (x_valid),
        .cfg_load    (cfg_load),
        .cfg_pattern (cfg_pattern),
        .cfg_len     (cfg_len),
        .cfg_overlap (cfg_overlap),
        .cfg_err     (cfg_err),
        .z           (z)
`ifdef SEQ_DET_MATCH_CNT_EN
        ,
        .match_cnt   (match_cnt),
        .cnt_clr     (cnt_clr)
`endif
    );

    // One clock: present (v,b), let the edge take it, sample at edge+1.
    task automatic step(input logic v, input logic b);
        x_valid = v;
        x       = b;
        @(posedge clk);
        #1;
        x_valid = 1'b0;
        x       = 1'b0;
    endtask

    // One clock with cfg_load asserted, optionally with a (to-be-dropped) valid bit.
    task automatic load(input logic [7:0] pat, input logic [3:0] len, input logic ovl,
                        input logic v, input logic b);
        cfg_load    = 1'b1;
        cfg_pattern = pat;
        cfg_len     = len;
        cfg_overlap = ovl;
        x_valid     = v;
        x           = b;
        @(posedge clk);
        #1;
        cfg_load = 1'b0;
        x_valid  = 1'b0;
        x        = 1'b0;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        #12;
        checks++;
        if (z !== 1'b0) begin
            failures++;
            $display("FAIL reset_z got=%b want=0", z);
        end
        checks++;
        if (cfg_err !== 1'b0) begin
            failures++;
            $display("FAIL reset_cfg_err got=%b want=0", cfg_err);
        end
`ifdef SEQ_DET_MATCH_CNT_EN
        checks++;
        if (match_cnt !== 4'd0) begin
            failures++;
            $display("FAIL reset_cnt got=%0d want=0", match_cnt);
        end
`endif
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    // Default config: 1010, overlapping. Matches after bits 4 and 6.
    task automatic test_default_overlap;
        logic [5:0] s;
        logic [5:0] e;
        s = 6'b101010;
        e = 6'b000101;
        for (int i = 5; i >= 0; i--) begin
            step(1'b1, s[i]);
            checks++;
            if (z !== e[i]) begin
                failures++;
                $display("FAIL default_ovl bit%0d z got=%b want=%b", 6 - i, z, e[i]);
            end
        end
`ifdef SEQ_DET_MATCH_CNT_EN
        checks++;
        if (match_cnt !== 4'd2) begin
            failures++;
            $display("FAIL default_ovl_cnt got=%0d want=2", match_cnt);
        end
`endif
    endtask

    // 1010 non-overlapping on 1010101010: fill clears at bit 4, so the next
    // full window of fresh bits is bits 5..8; bits 9,10 leave fill at 2.
    task automatic test_nonoverlap;
        logic [9:0] s;
        logic [9:0] e;
        load(8'h0A, 4'd4, 1'b0, 1'b0, 1'b0);
        checks++;
        if (cfg_err !== 1'b0) begin
            failures++;
            $display("FAIL nonovl_load_err got=%b want=0", cfg_err);
        end
        s = 10'b1010101010;
        e = 10'b0001000100;
        for (int i = 9; i >= 0; i--) begin
            step(1'b1, s[i]);
            checks++;
            if (z !== e[i]) begin
                failures++;
                $display("FAIL nonovl bit%0d z got=%b want=%b", 10 - i, z, e[i]);
            end
        end
    endtask

    // 1011 with three idle cycles between valid bits.
    task automatic test_gapped_valid;
        logic [3:0] s;
        s = 4'b1011;
        load(8'h0B, 4'd4, 1'b1, 1'b0, 1'b0);
        for (int i = 3; i >= 0; i--) begin
            step(1'b1, s[i]);
            checks++;
            if (z !== (i == 0)) begin
                failures++;
                $display("FAIL gapped bit%0d z got=%b want=%b", 4 - i, z, (i == 0));
            end
            for (int k = 0; k < 3; k++) begin
                step(1'b0, 1'b1);
                checks++;
                if (z !== 1'b0) begin
                    failures++;
                    $display("FAIL gapped idle%0d after bit%0d z got=%b want=0", k, 4 - i, z);
                end
            end
        end
    endtask

    task automatic test_invalid_load;
        load(8'h0A, 4'd4, 1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b1);
        step(1'b1, 1'b0);
        step(1'b1, 1'b1);
        // len=0 rejected; the 0 offered with it must not complete 1010.
        load(8'hFF, 4'd0, 1'b0, 1'b1, 1'b0);
        checks++;
        if (cfg_err !== 1'b1) begin
            failures++;
            $display("FAIL inv_len0_err got=%b want=1", cfg_err);
        end
        checks++;
        if (z !== 1'b0) begin
            failures++;
            $display("FAIL inv_len0_z got=%b want=0", z);
        end
        // History 101 kept, so this 0 completes 1010.
        step(1'b1, 1'b0);
        checks++;
        if (z !== 1'b1) begin
            failures++;
            $display("FAIL inv_keep_hist z got=%b want=1", z);
        end
        checks++;
        if (cfg_err !== 1'b0) begin
            failures++;
            $display("FAIL inv_err_pulse got=%b want=0", cfg_err);
        end
        load(8'hFF, 4'd9, 1'b0, 1'b0, 1'b0);
        checks++;
        if (cfg_err !== 1'b1) begin
            failures++;
            $display("FAIL inv_len9_err got=%b want=1", cfg_err);
        end
        // Still 1010 overlapping: ...1010 then 1,0 matches again.
        step(1'b1, 1'b1);
        checks++;
        if (z !== 1'b0) begin
            failures++;
            $display("FAIL inv_after_b1 z got=%b want=0", z);
        end
        step(1'b1, 1'b0);
        checks++;
        if (z !== 1'b1) begin
            failures++;
            $display("FAIL inv_after_b2 z got=%b want=1", z);
        end
    endtask

    task automatic test_boundary;
        logic [4:0] s;
        logic [4:0] e;
        logic [3:0] s2;
        // Full-length pattern, overlapping: z after bits 8 and 9.
        load(8'hFF, 4'd8, 1'b1, 1'b0, 1'b0);
        for (int i = 1; i <= 9; i++) begin
            step(1'b1, 1'b1);
            checks++;
            if (z !== (i >= 8)) begin
                failures++;
                $display("FAIL len8 bit%0d z got=%b want=%b", i, z, (i >= 8));
            end
        end
        // len=1, pattern[0]=0, upper bits must be ignored.
        load(8'hFE, 4'd1, 1'b1, 1'b0, 1'b0);
        s = 5'b01001;
        e = 5'b10110;
        for (int i = 4; i >= 0; i--) begin
            step(1'b1, s[i]);
            checks++;
            if (z !== e[i]) begin
                failures++;
                $display("FAIL len1_ovl bit%0d z got=%b want=%b", 5 - i, z, e[i]);
            end
        end
        // len=1, pattern[0]=1, non-overlapping: every 1 still matches.
        load(8'hA5, 4'd1, 1'b0, 1'b0, 1'b0);
        s2 = 4'b1101;
        for (int i = 3; i >= 0; i--) begin
            step(1'b1, s2[i]);
            checks++;
            if (z !== s2[i]) begin
                failures++;
                $display("FAIL len1_nonovl bit%0d z got=%b want=%b", 4 - i, z, s2[i]);
            end
        end
    endtask

`ifdef SEQ_DET_MATCH_CNT_EN
    task automatic test_counter;
        load(8'h01, 4'd1, 1'b1, 1'b0, 1'b0);
        cnt_clr = 1'b1;
        step(1'b1, 1'b1);
        cnt_clr = 1'b0;
        checks++;
        if (match_cnt !== 4'd1) begin
            failures++;
            $display("FAIL cnt_clr_and_match got=%0d want=1", match_cnt);
        end
        for (int i = 0; i < 20; i++) begin
            step(1'b1, 1'b1);
        end
        checks++;
        if (match_cnt !== 4'd15) begin
            failures++;
            $display("FAIL cnt_saturate got=%0d want=15", match_cnt);
        end
        cnt_clr = 1'b1;
        step(1'b0, 1'b0);
        cnt_clr = 1'b0;
        checks++;
        if (match_cnt !== 4'd0) begin
            failures++;
            $display("FAIL cnt_clear got=%0d want=0", match_cnt);
        end
    endtask
`endif

    task automatic test_reset_midstream;
        logic [4:0] s;
        logic [4:0] e;
        load(8'h0F, 4'd4, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b1);
        step(1'b1, 1'b1);
        step(1'b1, 1'b1);
        step(1'b1, 1'b1);
        checks++;
        if (z !== 1'b1) begin
            failures++;
            $display("FAIL rst_pre_match z got=%b want=1", z);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (z !== 1'b0) begin
            failures++;
            $display("FAIL rst_async_z got=%b want=0", z);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        // Three bits of default 1010, then reset: nothing may be remembered.
        step(1'b1, 1'b1);
        step(1'b1, 1'b0);
        step(1'b1, 1'b1);
        rst_n = 1'b0;
        #2;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        s = 5'b01010;
        e = 5'b00001;
        for (int i = 4; i >= 0; i--) begin
            step(1'b1, s[i]);
            checks++;
            if (z !== e[i]) begin
                failures++;
                $display("FAIL rst_restart bit%0d z got=%b want=%b", 5 - i, z, e[i]);
            end
        end
    endtask

    initial begin
        x           = 1'b0;
        x_valid     = 1'b0;
        cfg_load    = 1'b0;
        cfg_pattern = '0;
        cfg_len     = '0;
        cfg_overlap = 1'b0;
`ifdef SEQ_DET_MATCH_CNT_EN
        cnt_clr     = 1'b0;
`endif
        test_reset();
        test_default_overlap();
        test_nonoverlap();
        test_gapped_valid();
        test_invalid_load();
        test_boundary();
`ifdef SEQ_DET_MATCH_CNT_EN
        test_counter();
`endif
        test_reset_midstream();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
